alu_multicycle: RTL and testbench

//   Registered, parametrised ALU for the multi-cycle datapath, with a start/done handshake.

---
 rtl/alu_multicycle_if.sv | 25 ++
 rtl/alu_multicycle.sv | 202 ++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// Handshake and operand/result bundle between the control FSM and the multi-cycle ALU.
// The master side drives requests, and the slave side (the ALU) returns results.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       sel;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             ovf;

    modport master (
        output start, sel, op1, op2,
        input  busy, done, out, zero, ovf
    );

    modport slave (
        input  start, sel, op1, op2,
        output busy, done, out, zero, ovf
    );
endinterface

// File: rtl/alu_multicycle.sv
// Registered ALU with a start/done handshake. Logic, add/sub, slt and shift ops take one cycle.
// MUL/DIVU/REMU take WIDTH cycles on a single shared shift-add/subtract engine.
module alu_multicycle #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1,
    parameter bit DIV_EN = 1'b1
) (
    input logic              clk,
    input logic              reset,
    alu_multicycle_if.slave  bus
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = SH_W;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_ITER = 1'b1} state_t;
    typedef enum logic [1:0] {K_MUL = 2'b00, K_DIVU = 2'b01, K_REMU = 2'b10} kind_t;

    state_t           state_r;
    kind_t            kind_r;
    kind_t            kind_s;
    logic             busy_r;
    logic             done_r;
    logic             zero_r;
    logic             ovf_r;
    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] shf_r;
    logic [WIDTH-1:0] opb_r;
    logic [CNT_W-1:0] cnt_r;

    logic [WIDTH-1:0] add_s;
    logic [WIDTH-1:0] sub_s;
    logic [SH_W-1:0]  shamt_s;
    logic [WIDTH-1:0] res_s;
    logic             ovf_s;
    logic             iter_s;

    assign add_s   = bus.op1 + bus.op2;
    assign sub_s   = bus.op1 - bus.op2;
    assign shamt_s = bus.op2[SH_W-1:0];

    // Opcode decode and single-cycle result datapath
    always_comb begin
        res_s  = {WIDTH{1'b0}};
        ovf_s  = 1'b0;
        iter_s = 1'b0;
        kind_s = K_MUL;
        case (bus.sel)
            4'b0000: res_s = bus.op1 & bus.op2;
            4'b0001: res_s = bus.op1 | bus.op2;
            4'b0010: begin
                res_s = add_s;
                ovf_s = (bus.op1[WIDTH-1] == bus.op2[WIDTH-1]) && (add_s[WIDTH-1] != bus.op1[WIDTH-1]);
            end
            4'b0100: res_s = bus.op1 & ~bus.op2;
            4'b0101: res_s = bus.op1 | ~bus.op2;
            4'b0110: begin
                res_s = sub_s;
                ovf_s = (bus.op1[WIDTH-1] != bus.op2[WIDTH-1]) && (sub_s[WIDTH-1] != bus.op1[WIDTH-1]);
            end
            4'b0111: res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.op1) < $signed(bus.op2))};
            4'b1000: res_s = bus.op1 << shamt_s;
            4'b1001: res_s = bus.op1 >> shamt_s;
            4'b1010: res_s = $unsigned($signed(bus.op1) >>> shamt_s);
            4'b1100: begin
                iter_s = MUL_EN;
                kind_s = K_MUL;
            end
            4'b1110: begin
                iter_s = DIV_EN;
                kind_s = K_DIVU;
            end
            4'b1111: begin
                iter_s = DIV_EN;
                kind_s = K_REMU;
            end
            default: res_s = {WIDTH{1'b0}};
        endcase
    end

    // Engine step: MUL adds the shifted multiplicand when the multiplier LSB is set;
    // DIVU/REMU subtract the divisor from the shifted remainder (restoring).
    logic             idle_s;
    logic             e_div_s;
    logic [WIDTH-1:0] e_acc_s;
    logic [WIDTH-1:0] e_shf_s;
    logic [WIDTH-1:0] e_opb_s;
    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH+1:0] add_a_s;
    logic [WIDTH+1:0] add_b_s;
    logic [WIDTH+1:0] sum_s;
    logic             fits_s;
    logic [WIDTH-1:0] acc_nx_s;
    logic [WIDTH-1:0] shf_nx_s;
    logic [WIDTH-1:0] opb_nx_s;
    logic [WIDTH-1:0] iter_res_s;

    assign idle_s = (state_r == S_IDLE);

    // The accepting edge already performs the first step on the raw operands
    always_comb begin
        if (idle_s) begin
            e_acc_s = {WIDTH{1'b0}};
            e_shf_s = bus.op1;
            e_opb_s = bus.op2;
            e_div_s = (kind_s != K_MUL);
        end else begin
            e_acc_s = acc_r;
            e_shf_s = shf_r;
            e_opb_s = opb_r;
            e_div_s = (kind_r != K_MUL);
        end
    end

    assign rem_shift_s = {e_acc_s, e_shf_s[WIDTH-1]};
    assign add_a_s     = e_div_s ? {1'b0, rem_shift_s} : {2'b00, e_acc_s};
    assign add_b_s     = e_div_s ? ~{2'b00, e_opb_s} : {2'b00, e_opb_s};
    assign sum_s       = add_a_s + add_b_s + {{(WIDTH+1){1'b0}}, e_div_s};
    // Non-negative difference; it then always fits in WIDTH bits.
    assign fits_s      = (sum_s[WIDTH+1:WIDTH] == 2'b00);

    // Next engine register values for the current step
    always_comb begin
        if (e_div_s) begin
            acc_nx_s = fits_s ? sum_s[WIDTH-1:0] : rem_shift_s[WIDTH-1:0];
            shf_nx_s = {e_shf_s[WIDTH-2:0], fits_s};
            opb_nx_s = e_opb_s;
        end else begin
            acc_nx_s = e_shf_s[0] ? sum_s[WIDTH-1:0] : e_acc_s;
            shf_nx_s = {1'b0, e_shf_s[WIDTH-1:1]};
            opb_nx_s = {e_opb_s[WIDTH-2:0], 1'b0};
        end
    end

    assign iter_res_s = (kind_r == K_DIVU) ? shf_nx_s : acc_nx_s;

    // Control FSM, engine registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            kind_r  <= K_MUL;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            zero_r  <= 1'b0;
            ovf_r   <= 1'b0;
            out_r   <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            shf_r   <= {WIDTH{1'b0}};
            opb_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        if (iter_s) begin
                            state_r <= S_ITER;
                            busy_r  <= 1'b1;
                            kind_r  <= kind_s;
                            acc_r   <= acc_nx_s;
                            shf_r   <= shf_nx_s;
                            opb_r   <= opb_nx_s;
                            cnt_r   <= CNT_W'(WIDTH - 1);
                        end else begin
                            out_r  <= res_s;
                            zero_r <= (res_s == {WIDTH{1'b0}});
                            ovf_r  <= ovf_s;
                            done_r <= 1'b1;
                        end
                    end
                end
                S_ITER: begin
                    acc_r <= acc_nx_s;
                    shf_r <= shf_nx_s;
                    opb_r <= opb_nx_s;
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        out_r   <= iter_res_s;
                        zero_r  <= (iter_res_s == {WIDTH{1'b0}});
                        ovf_r   <= 1'b0;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.out  = out_r;
    assign bus.zero = zero_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle at WIDTH=32 with hand-computed expectations.
module tb_alu_multicycle;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_ANDN = 4'b0100;
    localparam logic [3:0] OP_ORN  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1110;
    localparam logic [3:0] OP_REMU = 4'b1111;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   bad;

    alu_multicycle_if #(.WIDTH(32)) bus ();

    alu_multicycle #(.WIDTH(32), .MUL_EN(1'b1), .DIV_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single-cycle op: start in this cycle, result must appear in the next one.
    task automatic run1(input string tag, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input logic ez, input logic eo);
        bus.start = 1'b1;
        bus.sel   = s;
        bus.op1   = a;
        bus.op2   = b;
        tick();
        bus.start = 1'b0;
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        chk(tag, bus.out, e);
        chk({tag, "_zo"}, {30'd0, bus.zero, bus.ovf}, {30'd0, ez, eo});
    endtask

    // Iterative op: busy for 31 cycles, done in the 32nd; optional ignored start at cycle inj.
    task automatic run_iter(input string tag, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] e, input logic ez, input int inj);
        bus.start = 1'b1;
        bus.sel   = s;
        bus.op1   = a;
        bus.op2   = b;
        tick();
        bus.start = 1'b0;
        bad = 0;
        for (int c = 1; c <= 31; c++) begin
            if ({bus.busy, bus.done} !== 2'b10) bad++;
            if (c == inj) begin
                bus.start = 1'b1;
                bus.sel   = OP_ADD;
                bus.op1   = 32'd1;
                bus.op2   = 32'd1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        bus.start = 1'b0;
        chk({tag, "_busywin"}, bad, 32'd0);
        chk({tag, "_bd"}, {30'd0, bus.busy, bus.done}, 32'd1);
        chk(tag, bus.out, e);
        chk({tag, "_zo"}, {30'd0, bus.zero, bus.ovf}, {30'd0, ez, 1'b0});
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.sel   = 4'b0000;
        bus.op1   = 32'd0;
        bus.op2   = 32'd0;
        tick();
        tick();
        chk("rst_out", bus.out, 32'd0);
        chk("rst_flags", {28'd0, bus.busy, bus.done, bus.zero, bus.ovf}, 32'd0);
        reset = 1'b0;
        tick();

        // Single-cycle ops, issued back to back
        run1("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        run1("sub_zero", OP_SUB, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
        run1("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 1'b1, 1'b0);
        run1("sub_ovf", OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run1("and", OP_AND, 32'hF0F0_0000, 32'h0F0F_0000, 32'd0, 1'b1, 1'b0);
        run1("or", OP_OR, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0);
        run1("andnot", OP_ANDN, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF000_F000, 1'b0, 1'b0);
        run1("ornot", OP_ORN, 32'h0000_0000, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b0);
        run1("slt_true", OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'd1, 1'b0, 1'b0);
        run1("slt_false", OP_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        run1("sra", OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0);
        run1("srl", OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0);
        run1("sll31", OP_SLL, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b0);
        run1("sll_amt_wrap", OP_SLL, 32'd1, 32'd33, 32'd2, 1'b0, 1'b0);
        tick();
        chk("hold_done", {31'd0, bus.done}, 32'd0);
        chk("hold_out", bus.out, 32'd2);

        // Iterative ops; the MUL also sees an ignored start at cycle k+5
        run_iter("mul", OP_MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b0, 5);
        run_iter("mul_signed", OP_MUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, 0);
        run_iter("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 0);
        run_iter("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 0);
        run_iter("divu_by0", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
        run_iter("remu_by0", OP_REMU, 32'd9, 32'd0, 32'd9, 1'b0, 0);
        run_iter("divu_small", OP_DIVU, 32'd7, 32'd100, 32'd0, 1'b1, 0);
        run_iter("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 1'b0, 0);

        // Start accepted in the done cycle of a divide
        run_iter("b2b_divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 0);
        run1("b2b_add", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);

        // Reset in the middle of a MUL
        bus.start = 1'b1;
        bus.sel   = OP_MUL;
        bus.op1   = 32'hFFFF_FFFF;
        bus.op2   = 32'd3;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        #1;
        chk("abort_out", bus.out, 32'd0);
        chk("abort_flags", {28'd0, bus.busy, bus.done, bus.zero, bus.ovf}, 32'd0);
        tick();
        reset = 1'b0;
        bad = 0;
        repeat (40) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        chk("abort_no_done", bad, 32'd0);

        run1("add_after_rst", OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
        run1("undef_1011", 4'b1011, 32'h1234_5678, 32'd1, 32'd0, 1'b1, 1'b0);
        run1("sub_ovf2", OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run1("undef_0011", 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        run1("add_4", OP_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0);
        run1("undef_1101", 4'b1101, 32'd7, 32'd9, 32'd0, 1'b1, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
